// File: rtl/core_insn_loader.sv
// Core-side instruction-load receiver: assembles scheduler chunks into a frame, captures R0, drives ready.
// Optional LOADER_ERR_COUNT_EN adds a saturating 8-bit protocol-error counter output (err_count).
module core_insn_loader #(
   parameter int INSN_LOAD_TIME = 4,
   parameter int INSN_W         = 32,
   parameter int CNT_W          = 2,
   parameter int REG_W          = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [CNT_W-1:0]                 insn_load_counter,
   input  logic [INSN_W-1:0]                insn_data,
   input  logic                             init_r0_en,
   input  logic [REG_W-1:0]                 init_r0,
   input  logic                             exec_done,
   output logic                             ready,
   output logic [INSN_LOAD_TIME*INSN_W-1:0] frame,
   output logic                             frame_valid,
   output logic                             r0_load,
   output logic [REG_W-1:0]                 r0_value,
   output logic                             proto_err
`ifdef LOADER_ERR_COUNT_EN
   ,
   output logic [7:0]                       err_count
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC} state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INSN_LOAD_TIME - 1);

   state_t                             state_q, state_d;
   logic [CNT_W-1:0]                   exp_q, exp_d;
   logic [INSN_LOAD_TIME*INSN_W-1:0]   frame_q, frame_d;
   logic                               fv_q, fv_d;
   logic                               r0l_q, r0l_d;
   logic [REG_W-1:0]                   r0v_q, r0v_d;
   logic                               err_q, err_d;

   logic accept;
   logic last;
   logic err_evt;

   // exp_q is 0 in IDLE, so one compare covers both chunk-0 entry and in-order LOAD chunks
   assign accept  = start && (state_q != S_EXEC) && (insn_load_counter == exp_q);
   assign last    = (insn_load_counter == LAST_IDX);
   assign err_evt = ((state_q == S_IDLE) && start && (insn_load_counter != '0)) ||
                    ((state_q == S_LOAD) && !accept) ||
                    ((state_q == S_EXEC) && start);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = last ? S_EXEC : S_LOAD;
         S_LOAD: state_d = accept ? (last ? S_EXEC : S_LOAD) : S_IDLE;
         S_EXEC: if (exec_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ready = (state_q != S_EXEC);
   end

   always_comb begin
      frame_d = frame_q;
      for (int k = 0; k < INSN_LOAD_TIME; k++) begin
         if (accept && (insn_load_counter == CNT_W'(k))) begin
            frame_d[k*INSN_W +: INSN_W] = insn_data;
         end
      end
      exp_d = (accept && !last) ? exp_q + CNT_W'(1) : '0;
      fv_d  = accept && last;
      r0l_d = accept && last && init_r0_en;
      r0v_d = r0l_d ? init_r0 : r0v_q;
      err_d = err_q | err_evt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q   <= '0;
         frame_q <= '0;
         fv_q    <= 1'b0;
         r0l_q   <= 1'b0;
         r0v_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         exp_q   <= exp_d;
         frame_q <= frame_d;
         fv_q    <= fv_d;
         r0l_q   <= r0l_d;
         r0v_q   <= r0v_d;
         err_q   <= err_d;
      end
   end

   assign frame       = frame_q;
   assign frame_valid = fv_q;
   assign r0_load     = r0l_q;
   assign r0_value    = r0v_q;
   assign proto_err   = err_q;

`ifdef LOADER_ERR_COUNT_EN
   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (err_evt && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign err_count = cnt_q;
`endif

endmodule

// File: tb/tb_core_insn_loader.sv
// Table-driven bench for core_insn_loader with a frame scoreboard; err_count checks under LOADER_ERR_COUNT_EN.
module tb_core_insn_loader;

   localparam int FW = 128;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [1:0]    insn_load_counter;
   logic [31:0]   insn_data;
   logic          init_r0_en;
   logic [7:0]    init_r0;
   logic          exec_done;
   logic          ready;
   logic [FW-1:0] frame;
   logic          frame_valid;
   logic          r0_load;
   logic [7:0]    r0_value;
   logic          proto_err;
`ifdef LOADER_ERR_COUNT_EN
   logic [7:0]    err_count;
`endif

   core_insn_loader dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .insn_load_counter (insn_load_counter),
      .insn_data         (insn_data),
      .init_r0_en        (init_r0_en),
      .init_r0           (init_r0),
      .exec_done         (exec_done),
      .ready             (ready),
      .frame             (frame),
      .frame_valid       (frame_valid),
      .r0_load           (r0_load),
      .r0_value          (r0_value),
      .proto_err         (proto_err)
`ifdef LOADER_ERR_COUNT_EN
      ,
      .err_count         (err_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          st;
      logic [1:0]    cnt;
      logic [31:0]   dat;
      logic          r0en;
      logic [7:0]    r0;
      logic          done;
      logic          e_rdy;
      logic          e_fv;
      logic          e_r0l;
      logic [7:0]    e_r0v;
      logic          e_err;
      logic          push;
      logic [FW-1:0] e_frame;
   } vec_t;

   vec_t          vecs[$];
   logic [FW-1:0] sb_q[$];
   int            n_tests = 0;
   int            n_fail  = 0;

   localparam logic [FW-1:0] F1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
   localparam logic [FW-1:0] F2 = {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000};
   localparam logic [FW-1:0] F3 = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
   localparam logic [FW-1:0] F4 = {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Pops the scoreboard whenever the DUT presents a frame
   task automatic sb_check();
      logic [FW-1:0] e;
      if (frame_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_frame_valid", 1'b1, 1'b0);
         end else begin
            e = sb_q.pop_front();
            chk("frame", frame, e);
         end
      end
   endtask

   task automatic drv(input logic st, input logic [1:0] c, input logic [31:0] d,
                      input logic r0en, input logic [7:0] r0, input logic done);
      start = st; insn_load_counter = c; insn_data = d;
      init_r0_en = r0en; init_r0 = r0; exec_done = done;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      sb_check();
   endtask

   task automatic add(input logic st, input logic [1:0] c, input logic [31:0] d,
                      input logic r0en, input logic [7:0] r0, input logic done,
                      input logic rdy, input logic fv, input logic r0l, input logic [7:0] r0v,
                      input logic err, input logic push, input logic [FW-1:0] fr);
      vec_t v;
      v.st = st; v.cnt = c; v.dat = d; v.r0en = r0en; v.r0 = r0; v.done = done;
      v.e_rdy = rdy; v.e_fv = fv; v.e_r0l = r0l; v.e_r0v = r0v; v.e_err = err;
      v.push = push; v.e_frame = fr;
      vecs.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      drv(0, 0, 0, 0, 0, 0);
      #12;
      chk("rst_ready", ready, 1'b1);
      chk("rst_frame", frame, '0);
      chk("rst_fv", frame_valid, 1'b0);
      chk("rst_r0_load", r0_load, 1'b0);
      chk("rst_r0_value", r0_value, 8'h00);
      chk("rst_proto_err", proto_err, 1'b0);
      reset = 1'b0;

      //  st c  data          r0en r0     done rdy fv r0l r0v    err push frame
      add(1, 0, 32'h11111111, 1, 8'h5A, 0,   1,  0, 0, 8'h00, 0,  0,   '0);
      add(1, 1, 32'h22222222, 1, 8'h5A, 0,   1,  0, 0, 8'h00, 0,  0,   '0);
      add(1, 2, 32'h33333333, 1, 8'h5A, 0,   1,  0, 0, 8'h00, 0,  0,   '0);
      add(1, 3, 32'h44444444, 1, 8'h5A, 0,   0,  1, 1, 8'h5A, 0,  1,   F1);
      add(0, 0, 32'h0,        0, 8'h00, 0,   0,  0, 0, 8'h5A, 0,  0,   '0);
      add(0, 0, 32'h0,        0, 8'h00, 1,   1,  0, 0, 8'h5A, 0,  0,   '0);
      add(1, 0, 32'hAAAA0000, 0, 8'h33, 0,   1,  0, 0, 8'h5A, 0,  0,   '0);
      add(1, 1, 32'hAAAA0001, 0, 8'h33, 0,   1,  0, 0, 8'h5A, 0,  0,   '0);
      add(1, 2, 32'hAAAA0002, 0, 8'h33, 0,   1,  0, 0, 8'h5A, 0,  0,   '0);
      add(1, 3, 32'hAAAA0003, 0, 8'h77, 0,   0,  1, 0, 8'h5A, 0,  1,   F2);
      add(0, 0, 32'h0,        0, 8'h00, 1,   1,  0, 0, 8'h5A, 0,  0,   '0);
      add(1, 0, 32'hB0B0B0B0, 0, 8'h00, 0,   1,  0, 0, 8'h5A, 0,  0,   '0);
      add(1, 1, 32'hB1B1B1B1, 0, 8'h00, 0,   1,  0, 0, 8'h5A, 0,  0,   '0);
      add(0, 0, 32'h0,        0, 8'h00, 0,   1,  0, 0, 8'h5A, 1,  0,   '0);
      add(1, 0, 32'hC0C0C0C0, 1, 8'h3C, 0,   1,  0, 0, 8'h5A, 1,  0,   '0);
      add(1, 1, 32'hC1C1C1C1, 1, 8'h3C, 0,   1,  0, 0, 8'h5A, 1,  0,   '0);
      add(1, 2, 32'hC2C2C2C2, 1, 8'h3C, 0,   1,  0, 0, 8'h5A, 1,  0,   '0);
      add(1, 3, 32'hC3C3C3C3, 1, 8'h3C, 0,   0,  1, 1, 8'h3C, 1,  1,   F3);
      add(0, 0, 32'h0,        0, 8'h00, 1,   1,  0, 0, 8'h3C, 1,  0,   '0);
      add(1, 2, 32'hDEADBEEF, 1, 8'h99, 0,   1,  0, 0, 8'h3C, 1,  0,   '0);
      add(1, 3, 32'hDEADBEEF, 1, 8'h99, 0,   1,  0, 0, 8'h3C, 1,  0,   '0);
      add(0, 0, 32'h0,        0, 8'h00, 1,   1,  0, 0, 8'h3C, 1,  0,   '0);
      add(1, 0, 32'hE0E0E0E0, 0, 8'h00, 0,   1,  0, 0, 8'h3C, 1,  0,   '0);
      add(1, 2, 32'hE2E2E2E2, 0, 8'h00, 0,   1,  0, 0, 8'h3C, 1,  0,   '0);
      add(1, 1, 32'hE1E1E1E1, 0, 8'h00, 0,   1,  0, 0, 8'h3C, 1,  0,   '0);

      foreach (vecs[i]) begin
         drv(vecs[i].st, vecs[i].cnt, vecs[i].dat, vecs[i].r0en, vecs[i].r0, vecs[i].done);
         if (vecs[i].push) sb_q.push_back(vecs[i].e_frame);
         step();
         chk($sformatf("v%0d_ready", i), ready, vecs[i].e_rdy);
         chk($sformatf("v%0d_fv", i), frame_valid, vecs[i].e_fv);
         chk($sformatf("v%0d_r0_load", i), r0_load, vecs[i].e_r0l);
         chk($sformatf("v%0d_r0_value", i), r0_value, vecs[i].e_r0v);
         chk($sformatf("v%0d_proto_err", i), proto_err, vecs[i].e_err);
      end
      // Partial frame after an aborted load keeps old chunks; only chunk 0 was rewritten
      chk("partial_frame", frame, {F3[127:32], 32'hE0E0E0E0});

      // Asynchronous reset between edges in the middle of a load
      drv(1, 0, 32'h12345678, 0, 0, 0);
      step();
      drv(1, 1, 32'h9ABCDEF0, 0, 0, 0);
      step();
      #2;
      reset = 1'b1;
      #1;
      chk("arst_ready", ready, 1'b1);
      chk("arst_frame", frame, '0);
      chk("arst_proto_err", proto_err, 1'b0);
      chk("arst_r0_value", r0_value, 8'h00);
      drv(0, 0, 0, 0, 0, 0);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drv(1, 2'(k), 32'hD0000000 + 32'(k), 1, 8'hA5, 0);
         if (k == 3) sb_q.push_back(F4);
         step();
      end
      chk("post_rst_fv", frame_valid, 1'b1);
      chk("post_rst_r0_value", r0_value, 8'hA5);
      chk("post_rst_err", proto_err, 1'b0);

      // start during EXEC is an error and does not disturb the frame
      drv(1, 0, 32'hFFFFFFFF, 0, 0, 0);
      step();
      chk("exec_start_err", proto_err, 1'b1);
      chk("exec_start_ready", ready, 1'b0);
      chk("exec_frame_hold", frame, F4);
      drv(0, 0, 0, 0, 0, 1);
      step();
      chk("exec_done_ready", ready, 1'b1);
      drv(0, 0, 0, 0, 0, 0);

`ifdef LOADER_ERR_COUNT_EN
      reset = 1'b1;
      #2;
      reset = 1'b0;
      chk("cnt_rst", err_count, 8'd0);
      drv(1, 1, 0, 0, 0, 0);
      step();
      chk("cnt_one", err_count, 8'd1);
      for (int k = 1; k < 300; k++) begin
         drv(1, 2'(1 + (k % 3)), 0, 0, 0, 0);
         step();
      end
      chk("cnt_sat", err_count, 8'd255);
      chk("cnt_ready", ready, 1'b1);
      drv(0, 0, 0, 0, 0, 0);
`endif

      chk("sb_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/core_insn_loader.md
Name: core_insn_loader

Overview:
Core-side receiver of the task scheduler's instruction-load protocol. One instance per core.
- Assembles the INSN_LOAD_TIME chunks streamed on the scheduler's start / insn_load_counter / insn_data lines into one instruction frame.
- Captures the optional initial R0 value.
- Drives the per-core ready line that the scheduler uses for its exec mask.
- Hands the completed frame to the core pipeline and holds ready low until the pipeline reports completion.

Parameters:
INSN_LOAD_TIME, 4, chunks per instruction frame (>=1)
INSN_W, 32, width of one insn_data chunk
CNT_W, 2, width of insn_load_counter (>= clog2(INSN_LOAD_TIME), minimum 1)
REG_W, 8, width of init_r0 / r0_value

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
start  in  1  this core's bit of the scheduler Start vector
insn_load_counter  in  CNT_W  chunk index from the scheduler
insn_data  in  INSN_W  chunk payload
init_r0_en  in  1  this core's bit of Init_R0_Vect
init_r0  in  REG_W  this core's slice of Init_R0
exec_done  in  1  pipeline finished executing the current frame (1-cycle pulse)
ready  out  1  to the scheduler Ready vector; 1 = free/idle
frame  out  INSN_LOAD_TIME*INSN_W  assembled frame; chunk k at [k*INSN_W +: INSN_W]
frame_valid  out  1  1-cycle pulse: frame complete, begin execution
r0_load  out  1  1-cycle pulse with frame_valid when R0 must be overwritten
r0_value  out  REG_W  captured init_r0
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, active-high) values:
  - state IDLE, ready=1, frame=0, frame_valid=0, r0_load=0, r0_value=0, proto_err=0, expected index=0.
  - Reset mid-load or mid-exec discards all partial data.
- States: IDLE, LOAD, EXEC.
- IDLE (ready=1):
  - start=1 & counter==0: write chunk 0 and set expected=1.
    - If INSN_LOAD_TIME==1, complete immediately as in LOAD-last.
    - Otherwise go to LOAD.
  - start=1 & counter!=0: set proto_err, ignore the chunk, stay in IDLE.
- LOAD (ready=1):
  - Each cycle must carry start=1 & counter==expected. Write the chunk and increment expected.
  - Last chunk (counter==INSN_LOAD_TIME-1): on the next edge
    - frame_valid=1 and r0_load = init_r0_en sampled on the last-chunk cycle;
    - r0_value = init_r0 if that sample was 1, otherwise r0_value is held;
    - ready=0; state goes to EXEC; expected=0.
  - start=0 mid-frame, or counter!=expected: set proto_err, return to IDLE, reset expected to 0.
    - Already-written chunks remain in frame but frame_valid is not raised.
- EXEC (ready=0):
  - start is ignored; start=1 in EXEC sets proto_err.
  - exec_done=1: ready=1 on the next edge, state goes to IDLE.
  - exec_done in the same cycle as the frame_valid edge is not possible; exec_done is sampled only in EXEC.
  - exec_done outside EXEC is ignored.
- Back-to-back frames: after ready returns to 1, the scheduler may assert start with counter=0 the very next cycle. This is accepted with no bubble.
- frame is held stable from frame_valid until the next chunk-0 write.
- Latency: last chunk to frame_valid/ready-fall is 1 cycle. exec_done to ready-rise is 1 cycle.
- Counter arithmetic is CNT_W-bit. Values >= INSN_LOAD_TIME are always protocol errors.
- proto_err clears only on reset.

Optional Feature:
Macro LOADER_ERR_COUNT_EN.
- Defined: adds output err_count [7:0]. It increments on every protocol-error event, saturates at 255, and is reset to 0. proto_err behaviour is unchanged.
- Undefined: the port and counter are absent.

Test Plan:
1. INSN_LOAD_TIME=4; start=1 for 4 cycles with counter 0,1,2,3 and data 0x11111111, 0x22222222, 0x33333333, 0x44444444; init_r0_en=1, init_r0=0x5A.
   -> Next cycle: frame=0x44444444_33333333_22222222_11111111, frame_valid=1, r0_load=1, r0_value=0x5A, ready=0.
2. After test 1, pulse exec_done.
   -> ready=1 next cycle. A new load with init_r0_en=0 gives r0_load=0 and r0_value stays 0x5A.
3. In IDLE, start=1 with counter=2.
   -> proto_err=1, state stays IDLE, ready=1, no frame_valid.
4. Load chunks 0,1, then start=0 for one cycle.
   -> proto_err=1, back to IDLE. A subsequent full 0..3 load completes normally with frame_valid.
5. Assert reset asynchronously (between edges) mid-LOAD after chunk 1.
   -> ready=1, frame=0, proto_err=0 immediately. A full load after reset release succeeds.
6. Build with LOADER_ERR_COUNT_EN; inject 300 bad-index starts in IDLE.
   -> err_count=255, saturated.
